// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for fetch_queue: fetch packet in, two head entries out.
// master = fetch/decode side, slave = the queue.
interface fetch_queue_if #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PHT_ADDRESS = 9,
    parameter int unsigned GHR_SIZE    = 9,
    parameter int unsigned RAS_ADDRESS = 3
);
    logic                   fq_in_valid;
    logic                   fq_in_ready;
    logic [XLEN-1:0]        fq_in_pc;
    logic [31:0]            fq_in_instr1;
    logic [31:0]            fq_in_instr2;
    logic                   fq_in_pred_taken1;
    logic                   fq_in_pred_taken2;
    logic [XLEN-1:0]        fq_in_pred_target1;
    logic [XLEN-1:0]        fq_in_pred_target2;
    logic [PHT_ADDRESS-1:0] fq_in_pht_index1;
    logic [PHT_ADDRESS-1:0] fq_in_pht_index2;
    logic [GHR_SIZE-1:0]    fq_in_ghr;
    logic [RAS_ADDRESS-1:0] fq_in_sp_snap;
    logic [1:0]             dq_take;

    logic                   fq_out_valid1;
    logic                   fq_out_valid2;
    logic [XLEN-1:0]        fq_out_pc1;
    logic [XLEN-1:0]        fq_out_pc2;
    logic [31:0]            fq_out_instr1;
    logic [31:0]            fq_out_instr2;
    logic                   fq_out_pred_taken1;
    logic                   fq_out_pred_taken2;
    logic [XLEN-1:0]        fq_out_pred_target1;
    logic [XLEN-1:0]        fq_out_pred_target2;
    logic [PHT_ADDRESS-1:0] fq_out_pht_index1;
    logic [PHT_ADDRESS-1:0] fq_out_pht_index2;
    logic [GHR_SIZE-1:0]    fq_out_ghr1;
    logic [GHR_SIZE-1:0]    fq_out_ghr2;
    logic [RAS_ADDRESS-1:0] fq_out_sp_snap1;
    logic [RAS_ADDRESS-1:0] fq_out_sp_snap2;

    modport master (
        output fq_in_valid, fq_in_pc, fq_in_instr1, fq_in_instr2,
               fq_in_pred_taken1, fq_in_pred_taken2,
               fq_in_pred_target1, fq_in_pred_target2,
               fq_in_pht_index1, fq_in_pht_index2,
               fq_in_ghr, fq_in_sp_snap, dq_take,
        input  fq_in_ready,
               fq_out_valid1, fq_out_valid2, fq_out_pc1, fq_out_pc2,
               fq_out_instr1, fq_out_instr2,
               fq_out_pred_taken1, fq_out_pred_taken2,
               fq_out_pred_target1, fq_out_pred_target2,
               fq_out_pht_index1, fq_out_pht_index2,
               fq_out_ghr1, fq_out_ghr2, fq_out_sp_snap1, fq_out_sp_snap2
    );

    modport slave (
        input  fq_in_valid, fq_in_pc, fq_in_instr1, fq_in_instr2,
               fq_in_pred_taken1, fq_in_pred_taken2,
               fq_in_pred_target1, fq_in_pred_target2,
               fq_in_pht_index1, fq_in_pht_index2,
               fq_in_ghr, fq_in_sp_snap, dq_take,
        output fq_in_ready,
               fq_out_valid1, fq_out_valid2, fq_out_pc1, fq_out_pc2,
               fq_out_instr1, fq_out_instr2,
               fq_out_pred_taken1, fq_out_pred_taken2,
               fq_out_pred_target1, fq_out_pred_target2,
               fq_out_pht_index1, fq_out_pht_index2,
               fq_out_ghr1, fq_out_ghr2, fq_out_sp_snap1, fq_out_sp_snap2
    );
endinterface

// File: rtl/fetch_queue.sv
// Two-in/two-out fetch queue between fetch and decode, emptied on mispredict flush.
// Optional FQ_STALL_CNT_EN adds fq_stall_cycles, counting cycles fetch is held off.
module fetch_queue #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned PHT_ADDRESS = 9,
    parameter int unsigned GHR_SIZE    = 9,
    parameter int unsigned RAS_ADDRESS = 3
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     flush,
    fetch_queue_if.slave             bus,
    output logic [$clog2(DEPTH):0]   fq_count
`ifdef FQ_STALL_CNT_EN
    ,
    output logic [31:0]              fq_stall_cycles
`endif
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [31:0]            instr;
        logic                   pred_taken;
        logic [XLEN-1:0]        pred_target;
        logic [PHT_ADDRESS-1:0] pht_index;
        logic [GHR_SIZE-1:0]    ghr;
        logic [RAS_ADDRESS-1:0] sp_snap;
    } entry_t;

    entry_t mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] tail_p1;
    logic [PTR_W-1:0] head_p1;
    logic             in_ready;
    logic [1:0]       n_enq;
    logic [1:0]       n_deq;
    logic [1:0]       take;
    entry_t           slot1;
    entry_t           slot2;
    entry_t           rd1;
    entry_t           rd2;

    assign in_ready = (count <= CNT_W'(DEPTH - 2));
    assign tail_p1  = tail + PTR_W'(1);
    assign head_p1  = head + PTR_W'(1);

    // Enqueue size: a predicted-taken slot 1 makes slot 2 wrong-path, so it is dropped.
    always_comb begin
        n_enq = 2'd0;
        if (bus.fq_in_valid && in_ready && !flush) begin
            n_enq = bus.fq_in_pred_taken1 ? 2'd1 : 2'd2;
        end
    end

    // Dequeue size: decode asks for up to two; never more than are held.
    always_comb begin
        take  = (bus.dq_take == 2'd3) ? 2'd2 : bus.dq_take;
        n_deq = take;
        if (count < CNT_W'(take)) begin
            n_deq = count[1:0];
        end
    end

    always_comb begin
        slot1.pc          = bus.fq_in_pc;
        slot1.instr       = bus.fq_in_instr1;
        slot1.pred_taken  = bus.fq_in_pred_taken1;
        slot1.pred_target = bus.fq_in_pred_target1;
        slot1.pht_index   = bus.fq_in_pht_index1;
        slot1.ghr         = bus.fq_in_ghr;
        slot1.sp_snap     = bus.fq_in_sp_snap;
        slot2.pc          = bus.fq_in_pc + XLEN'(4);
        slot2.instr       = bus.fq_in_instr2;
        slot2.pred_taken  = bus.fq_in_pred_taken2;
        slot2.pred_target = bus.fq_in_pred_target2;
        slot2.pht_index   = bus.fq_in_pht_index2;
        slot2.ghr         = bus.fq_in_ghr;
        slot2.sp_snap     = bus.fq_in_sp_snap;
    end

    // Pointer/occupancy state; flush wins over any enqueue or dequeue of the cycle.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_deq);
            tail  <= tail + PTR_W'(n_enq);
            count <= count + CNT_W'(n_enq) - CNT_W'(n_deq);
        end
    end

    // Payload storage carries no reset; validity comes from count alone.
    always_ff @(posedge CLK) begin
        if (n_enq != 2'd0) begin
            mem[tail] <= slot1;
        end
        if (n_enq == 2'd2) begin
            mem[tail_p1] <= slot2;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (count >= CNT_W'(1)) begin
            rd1 = mem[head];
        end
        if (count >= CNT_W'(2)) begin
            rd2 = mem[head_p1];
        end
    end

    assign bus.fq_in_ready         = in_ready;
    assign bus.fq_out_valid1       = (count >= CNT_W'(1));
    assign bus.fq_out_valid2       = (count >= CNT_W'(2));
    assign bus.fq_out_pc1          = rd1.pc;
    assign bus.fq_out_pc2          = rd2.pc;
    assign bus.fq_out_instr1       = rd1.instr;
    assign bus.fq_out_instr2       = rd2.instr;
    assign bus.fq_out_pred_taken1  = rd1.pred_taken;
    assign bus.fq_out_pred_taken2  = rd2.pred_taken;
    assign bus.fq_out_pred_target1 = rd1.pred_target;
    assign bus.fq_out_pred_target2 = rd2.pred_target;
    assign bus.fq_out_pht_index1   = rd1.pht_index;
    assign bus.fq_out_pht_index2   = rd2.pht_index;
    assign bus.fq_out_ghr1         = rd1.ghr;
    assign bus.fq_out_ghr2         = rd2.ghr;
    assign bus.fq_out_sp_snap1     = rd1.sp_snap;
    assign bus.fq_out_sp_snap2     = rd2.sp_snap;
    assign fq_count                = count;

`ifdef FQ_STALL_CNT_EN
    // Cycles where fetch offered a packet but the queue had no room.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            fq_stall_cycles <= '0;
        end else if (bus.fq_in_valid && !in_ready && !flush) begin
            fq_stall_cycles <= fq_stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: fill, taken-drop, full, wrap, flush, reset.
module tb_fetch_queue;
    localparam int unsigned XLEN = 32;

    logic       CLK;
    logic       reset;
    logic       flush;
    logic [3:0] fq_count;
`ifdef FQ_STALL_CNT_EN
    logic [31:0] fq_stall_cycles;
`endif
    int tests;
    int fails;

    fetch_queue_if #(.XLEN(XLEN), .PHT_ADDRESS(9), .GHR_SIZE(9), .RAS_ADDRESS(3)) bus ();

    fetch_queue #(.XLEN(XLEN), .DEPTH(8), .PHT_ADDRESS(9), .GHR_SIZE(9), .RAS_ADDRESS(3)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .flush    (flush),
        .bus      (bus),
        .fq_count (fq_count)
`ifdef FQ_STALL_CNT_EN
        ,
        .fq_stall_cycles (fq_stall_cycles)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Packet fields are derived from pc so expectations can be recomputed from it.
    task automatic set_in(input logic v, input logic [31:0] pc, input logic t1,
                          input logic [1:0] take, input logic fl);
        bus.fq_in_valid        = v;
        bus.fq_in_pc           = pc;
        bus.fq_in_instr1       = pc ^ 32'hDEAD0000;
        bus.fq_in_instr2       = pc ^ 32'hBEEF0000;
        bus.fq_in_pred_taken1  = t1;
        bus.fq_in_pred_taken2  = 1'b0;
        bus.fq_in_pred_target1 = pc + 32'h200;
        bus.fq_in_pred_target2 = pc + 32'h300;
        bus.fq_in_pht_index1   = pc[10:2];
        bus.fq_in_pht_index2   = pc[10:2] + 9'd1;
        bus.fq_in_ghr          = pc[12:4];
        bus.fq_in_sp_snap      = pc[10:8];
        bus.dq_take            = take;
        flush                  = fl;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic t1,
                         input logic [1:0] take, input logic fl);
        @(negedge CLK);
        set_in(v, pc, t1, take, fl);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
        #1;
        tests++; if (fq_count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", fq_count); end
        tests++; if (bus.fq_out_valid1 !== 1'b0 || bus.fq_out_valid2 !== 1'b0) begin fails++; $display("FAIL reset_valid got %b%b exp 00", bus.fq_out_valid1, bus.fq_out_valid2); end
        tests++; if (bus.fq_in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", bus.fq_in_ready); end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        reset = 1'b1;
`ifdef FQ_STALL_CNT_EN
        #1;
        tests++; if (fq_stall_cycles !== 32'd0) begin fails++; $display("FAIL reset_stall got %0d exp 0", fq_stall_cycles); end
`endif
    endtask

    task automatic test_basic();
        @(negedge CLK);
        set_in(1'b1, 32'h100, 1'b0, 2'd0, 1'b0);
        #1;
        tests++; if (bus.fq_out_valid1 !== 1'b0) begin fails++; $display("FAIL basic_no_bypass got %b exp 0", bus.fq_out_valid1); end
        @(posedge CLK);
        #1;
        tests++; if (fq_count !== 4'd2) begin fails++; $display("FAIL basic_count got %0d exp 2", fq_count); end
        tests++; if (bus.fq_out_valid1 !== 1'b1 || bus.fq_out_valid2 !== 1'b1) begin fails++; $display("FAIL basic_valid got %b%b exp 11", bus.fq_out_valid1, bus.fq_out_valid2); end
        tests++; if (bus.fq_out_pc1 !== 32'h100 || bus.fq_out_pc2 !== 32'h104) begin fails++; $display("FAIL basic_pc got %h/%h exp 100/104", bus.fq_out_pc1, bus.fq_out_pc2); end
        tests++; if (bus.fq_out_instr1 !== 32'hDEAD0100 || bus.fq_out_instr2 !== 32'hBEEF0100) begin fails++; $display("FAIL basic_instr got %h/%h exp dead0100/beef0100", bus.fq_out_instr1, bus.fq_out_instr2); end
        tests++; if (bus.fq_out_ghr1 !== 9'h010 || bus.fq_out_ghr2 !== 9'h010) begin fails++; $display("FAIL basic_ghr got %h/%h exp 010/010", bus.fq_out_ghr1, bus.fq_out_ghr2); end
        tests++; if (bus.fq_out_sp_snap1 !== 3'd1 || bus.fq_out_sp_snap2 !== 3'd1) begin fails++; $display("FAIL basic_sp got %0d/%0d exp 1/1", bus.fq_out_sp_snap1, bus.fq_out_sp_snap2); end
        tests++; if (bus.fq_out_pht_index1 !== 9'h040 || bus.fq_out_pht_index2 !== 9'h041) begin fails++; $display("FAIL basic_pht got %h/%h exp 040/041", bus.fq_out_pht_index1, bus.fq_out_pht_index2); end
        tests++; if (bus.fq_out_pred_target2 !== 32'h400) begin fails++; $display("FAIL basic_target2 got %h exp 400", bus.fq_out_pred_target2); end
        drive(1'b0, 32'h0, 1'b0, 2'd2, 1'b0);
        tests++; if (fq_count !== 4'd0 || bus.fq_out_valid1 !== 1'b0) begin fails++; $display("FAIL basic_drain got cnt %0d v1 %b exp 0/0", fq_count, bus.fq_out_valid1); end
    endtask

    task automatic test_taken();
        drive(1'b1, 32'h200, 1'b1, 2'd0, 1'b0);
        tests++; if (fq_count !== 4'd1) begin fails++; $display("FAIL taken_count got %0d exp 1", fq_count); end
        tests++; if (bus.fq_out_valid2 !== 1'b0 || bus.fq_out_pc2 !== 32'h0) begin fails++; $display("FAIL taken_slot2 got v2 %b pc2 %h exp 0/0", bus.fq_out_valid2, bus.fq_out_pc2); end
        tests++; if (bus.fq_out_pred_target1 !== 32'h400 || bus.fq_out_pred_taken1 !== 1'b1) begin fails++; $display("FAIL taken_target got %h/%b exp 400/1", bus.fq_out_pred_target1, bus.fq_out_pred_taken1); end
        drive(1'b0, 32'h0, 1'b0, 2'd1, 1'b0);
        tests++; if (fq_count !== 4'd0) begin fails++; $display("FAIL taken_drain got %0d exp 0", fq_count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1000 + 32'(8 * i), 1'b0, 2'd0, 1'b0);
            tests++; if (fq_count !== 4'(2 * (i + 1))) begin fails++; $display("FAIL full_fill%0d got %0d exp %0d", i, fq_count, 2 * (i + 1)); end
            if (i == 2) begin
                tests++; if (bus.fq_in_ready !== 1'b1) begin fails++; $display("FAIL full_ready6 got %b exp 1", bus.fq_in_ready); end
            end
        end
        tests++; if (bus.fq_in_ready !== 1'b0) begin fails++; $display("FAIL full_ready8 got %b exp 0", bus.fq_in_ready); end
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h2000, 1'b0, 2'd0, 1'b0);
        tests++; if (fq_count !== 4'd8 || bus.fq_out_pc1 !== 32'h1000) begin fails++; $display("FAIL full_held got cnt %0d pc1 %h exp 8/1000", fq_count, bus.fq_out_pc1); end
`ifdef FQ_STALL_CNT_EN
        tests++; if (fq_stall_cycles !== 32'd3) begin fails++; $display("FAIL full_stall got %0d exp 3", fq_stall_cycles); end
`endif
        drive(1'b1, 32'h2000, 1'b0, 2'd2, 1'b0);
        tests++; if (fq_count !== 4'd6 || bus.fq_out_pc1 !== 32'h1008) begin fails++; $display("FAIL full_deq got cnt %0d pc1 %h exp 6/1008", fq_count, bus.fq_out_pc1); end
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b0, 2'd2, 1'b0);
        tests++; if (fq_count !== 4'd0) begin fails++; $display("FAIL full_drain got %0d exp 0", fq_count); end
    endtask

    task automatic test_wrap();
        drive(1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
        drive(1'b1, 32'h300, 1'b1, 2'd0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 2'd1, 1'b0);
        tests++; if (fq_count !== 4'd0) begin fails++; $display("FAIL wrap_pre got %0d exp 0", fq_count); end
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h500 + 32'(8 * i), 1'b0, 2'd0, 1'b0);
        tests++; if (fq_count !== 4'd6 || bus.fq_in_ready !== 1'b1) begin fails++; $display("FAIL wrap_six got cnt %0d rdy %b exp 6/1", fq_count, bus.fq_in_ready); end
        drive(1'b1, 32'h518, 1'b0, 2'd2, 1'b0);
        tests++; if (fq_count !== 4'd6) begin fails++; $display("FAIL wrap_simul got %0d exp 6", fq_count); end
        tests++; if (bus.fq_out_pc1 !== 32'h508 || bus.fq_out_pc2 !== 32'h50C) begin fails++; $display("FAIL wrap_pc_a got %h/%h exp 508/50c", bus.fq_out_pc1, bus.fq_out_pc2); end
        drive(1'b0, 32'h0, 1'b0, 2'd2, 1'b0);
        tests++; if (bus.fq_out_pc1 !== 32'h510 || bus.fq_out_pc2 !== 32'h514) begin fails++; $display("FAIL wrap_pc_b got %h/%h exp 510/514", bus.fq_out_pc1, bus.fq_out_pc2); end
        drive(1'b0, 32'h0, 1'b0, 2'd2, 1'b0);
        tests++; if (bus.fq_out_pc1 !== 32'h518 || bus.fq_out_pc2 !== 32'h51C || fq_count !== 4'd2) begin fails++; $display("FAIL wrap_pc_c got %h/%h cnt %0d exp 518/51c/2", bus.fq_out_pc1, bus.fq_out_pc2, fq_count); end
        drive(1'b0, 32'h0, 1'b0, 2'd2, 1'b0);
        tests++; if (fq_count !== 4'd0) begin fails++; $display("FAIL wrap_drain got %0d exp 0", fq_count); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h600, 1'b0, 2'd0, 1'b0);
        drive(1'b1, 32'h608, 1'b0, 2'd0, 1'b0);
        drive(1'b1, 32'h610, 1'b1, 2'd0, 1'b0);
        tests++; if (fq_count !== 4'd5) begin fails++; $display("FAIL flush_pre got %0d exp 5", fq_count); end
        drive(1'b1, 32'h700, 1'b0, 2'd2, 1'b1);
        tests++; if (fq_count !== 4'd0 || bus.fq_in_ready !== 1'b1) begin fails++; $display("FAIL flush_state got cnt %0d rdy %b exp 0/1", fq_count, bus.fq_in_ready); end
        tests++; if (bus.fq_out_valid1 !== 1'b0 || bus.fq_out_valid2 !== 1'b0 || bus.fq_out_pc1 !== 32'h0) begin fails++; $display("FAIL flush_out got %b%b pc1 %h exp 00/0", bus.fq_out_valid1, bus.fq_out_valid2, bus.fq_out_pc1); end
    endtask

    task automatic test_underflow();
        drive(1'b1, 32'h800, 1'b1, 2'd0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 2'd2, 1'b0);
        tests++; if (fq_count !== 4'd0 || bus.fq_out_valid1 !== 1'b0) begin fails++; $display("FAIL under_one got cnt %0d v1 %b exp 0/0", fq_count, bus.fq_out_valid1); end
        drive(1'b1, 32'h900, 1'b0, 2'd2, 1'b0);
        tests++; if (fq_count !== 4'd2 || bus.fq_out_pc1 !== 32'h900) begin fails++; $display("FAIL under_empty_enq got cnt %0d pc1 %h exp 2/900", fq_count, bus.fq_out_pc1); end
        drive(1'b1, 32'h908, 1'b0, 2'd0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 2'd3, 1'b0);
        tests++; if (fq_count !== 4'd2 || bus.fq_out_pc1 !== 32'h908) begin fails++; $display("FAIL under_take3 got cnt %0d pc1 %h exp 2/908", fq_count, bus.fq_out_pc1); end
        drive(1'b0, 32'h0, 1'b0, 2'd2, 1'b0);
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'hA00, 1'b0, 2'd0, 1'b0);
        drive(1'b1, 32'hA08, 1'b0, 2'd0, 1'b0);
        tests++; if (fq_count !== 4'd4) begin fails++; $display("FAIL arst_pre got %0d exp 4", fq_count); end
        @(negedge CLK);
        set_in(1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        tests++; if (fq_count !== 4'd0 || bus.fq_out_valid1 !== 1'b0 || bus.fq_out_valid2 !== 1'b0) begin fails++; $display("FAIL arst_now got cnt %0d v %b%b exp 0/00", fq_count, bus.fq_out_valid1, bus.fq_out_valid2); end
        tests++; if (bus.fq_in_ready !== 1'b1) begin fails++; $display("FAIL arst_ready got %b exp 1", bus.fq_in_ready); end
        @(negedge CLK);
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
        tests++; if (fq_count !== 4'd0) begin fails++; $display("FAIL arst_after got %0d exp 0", fq_count); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_taken();
        test_full();
        test_wrap();
        test_flush();
        test_underflow();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout after %0d tests", tests);
        $fatal(1, "timeout");
    end
endmodule
